// File: rtl/ram_req_pkg.sv
// Shared types and constants for the change-detect RAM requester and its RAM.
package ram_req_pkg;

  localparam int unsigned RAM_WORD_W          = 32;
  localparam int unsigned RAM_MEM_WORDS_DEF   = 4096;
  localparam int unsigned RAM_TIMEOUT_CYC_DEF = 64;

  typedef enum logic [1:0] {
    SYNC,
    IDLE,
    WAIT_LOW,
    WAIT_HIGH
  } state_e;

  // Lines driven towards the RAM; the RAM reacts to any change of this tuple.
  typedef struct packed {
    logic                  wr;
    logic [RAM_WORD_W-1:0] addr;
    logic [RAM_WORD_W-1:0] data;
  } mem_cmd_t;

  function automatic logic addr_in_range(input logic [RAM_WORD_W-1:0] addr,
                                         input int unsigned words);
    return addr < RAM_WORD_W'(words);
  endfunction

endpackage

// File: rtl/ram_requester_if.sv
// Client request/response port plus RAM handshake lines of the requester.
interface ram_requester_if;
  import ram_req_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wr;
  logic [RAM_WORD_W-1:0] req_addr;
  logic [RAM_WORD_W-1:0] req_wdata;
  logic                  rsp_valid;
  logic [RAM_WORD_W-1:0] rsp_rdata;
  logic                  rsp_err;
  logic [RAM_WORD_W-1:0] mem_data;
  logic [RAM_WORD_W-1:0] mem_addr;
  logic                  mem_wr;
  logic                  mem_response;
  logic [RAM_WORD_W-1:0] mem_out;

  // Requester side.
  modport master (
    input  req_valid, req_wr, req_addr, req_wdata, mem_response, mem_out,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_data, mem_addr, mem_wr
  );

  // Client and RAM side.
  modport slave (
    output req_valid, req_wr, req_addr, req_wdata, mem_response, mem_out,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_data, mem_addr, mem_wr
  );

endinterface

// File: rtl/ram_req_watchdog.sv
// Per-phase timeout counter: restarts on each response-phase entry, flags expiry.
module ram_req_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expire_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC) + 1;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run && (cnt != CNT_W'(TIMEOUT_CYC))) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Fires on the edge at which the count would reach TIMEOUT_CYC.
  assign expire_c = run && !clear && (cnt == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/ram_requester.sv
// Initiator for the change-detect word RAM handshake, one transaction in flight.
// Optional phase timeout enabled by defining RAM_REQ_TIMEOUT_EN.
module ram_requester
  import ram_req_pkg::*;
#(
  parameter int unsigned MEM_WORDS = RAM_MEM_WORDS_DEF
`ifdef RAM_REQ_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYC = RAM_TIMEOUT_CYC_DEF
`endif
) (
  input logic            clk,
  input logic            rst,
  ram_requester_if.master bus
);

  state_e                state;
  logic                  req_ready_q;
  logic                  rsp_valid_q;
  logic                  rsp_err_q;
  logic [RAM_WORD_W-1:0] rsp_rdata_q;
  mem_cmd_t              cmd_q;
  logic                  pend;
  logic                  pend_err;

  logic accept_c;
  logic oob_c;
  logic elide_c;
  logic expire_c;

  assign accept_c = (state == IDLE) && !pend && req_ready_q && bus.req_valid;
  assign oob_c    = !addr_in_range(bus.req_addr, MEM_WORDS);
  // Re-driving an identical write would present no change to the RAM.
  assign elide_c  = bus.req_wr && cmd_q.wr &&
                    (bus.req_addr == cmd_q.addr) && (bus.req_wdata == cmd_q.data);

`ifdef RAM_REQ_TIMEOUT_EN
  logic wd_clear_c;
  logic wd_run_c;

  assign wd_clear_c = accept_c || ((state == WAIT_LOW) && !bus.mem_response);
  assign wd_run_c   = (state == WAIT_LOW) || (state == WAIT_HIGH);

  ram_req_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clear    (wd_clear_c),
    .run      (wd_run_c),
    .expire_c (expire_c)
  );
`else
  assign expire_c = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SYNC;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      cmd_q       <= '0;
      pend        <= 1'b0;
      pend_err    <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      case (state)
        // RAM has no reset: let any aborted access settle before serving requests.
        SYNC: begin
          req_ready_q <= 1'b0;
          if (bus.mem_response) begin
            state <= IDLE;
          end
        end

        IDLE: begin
          if (pend) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= pend_err;
            pend        <= 1'b0;
          end else if (accept_c) begin
            req_ready_q <= 1'b0;
            if (oob_c) begin
              pend     <= 1'b1;
              pend_err <= 1'b1;
            end else if (elide_c) begin
              pend     <= 1'b1;
              pend_err <= 1'b0;
            end else begin
              cmd_q.addr <= bus.req_addr;
              cmd_q.wr   <= bus.req_wr;
              // Reads flip the ignored data lines so repeats still look like a change.
              cmd_q.data <= bus.req_wr ? bus.req_wdata : ~cmd_q.data;
              state      <= WAIT_LOW;
            end
          end else begin
            req_ready_q <= 1'b1;
          end
        end

        WAIT_LOW: begin
          if (!bus.mem_response) begin
            state <= WAIT_HIGH;
          end else if (expire_c) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            state       <= SYNC;
          end
        end

        WAIT_HIGH: begin
          if (bus.mem_response) begin
            rsp_valid_q <= 1'b1;
            if (!cmd_q.wr) begin
              rsp_rdata_q <= bus.mem_out;
            end
            state <= IDLE;
          end else if (expire_c) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            state       <= SYNC;
          end
        end

        default: begin
          state <= SYNC;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.mem_data  = cmd_q.data;
  assign bus.mem_addr  = cmd_q.addr;
  assign bus.mem_wr    = cmd_q.wr;

endmodule

// File: tb/tb_ram_requester.sv
// Randomized bench for ram_requester against a change-detect RAM model and a word-level reference.
module tb_ram_requester;
  import ram_req_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_requester_if bus();

  ram_requester #(
    .MEM_WORDS (4096)
`ifdef RAM_REQ_TIMEOUT_EN
    , .TIMEOUT_CYC (8)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Change-detect RAM: a new (data, addr, wr) drops response, completes after ram_delay extra negedges.
  logic [31:0] ram [4096];
  logic [31:0] sh_data = '0;
  logic [31:0] sh_addr = '0;
  logic        sh_wr   = 1'b0;
  logic        ram_resp = 1'b1;
  logic        busy = 1'b0;
  int          busy_cnt = 0;
  int          ram_delay = 0;
  logic        hold_low = 1'b0;
  logic        hold_high = 1'b0;

  assign bus.mem_response = hold_low ? 1'b0 : (hold_high ? 1'b1 : ram_resp);

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = '0;
    bus.mem_out = '0;
  end

  always @(negedge clk) begin
    if (busy) begin
      if (busy_cnt > 0) begin
        busy_cnt--;
      end else begin
        if (sh_wr) ram[sh_addr[11:0]] = sh_data;
        else bus.mem_out = ram[sh_addr[11:0]];
        ram_resp = 1'b1;
        busy = 1'b0;
      end
    end else if ({bus.mem_data, bus.mem_addr, bus.mem_wr} != {sh_data, sh_addr, sh_wr}) begin
      sh_data  = bus.mem_data;
      sh_addr  = bus.mem_addr;
      sh_wr    = bus.mem_wr;
      ram_resp = 1'b0;
      busy     = 1'b1;
      busy_cnt = ram_delay;
    end
  end

  // Reference: word contents and the lines the requester is expected to drive.
  logic [31:0] ref_mem [4096];
  logic [31:0] drv_addr = '0;
  logic [31:0] drv_data = '0;
  logic        drv_wr = 1'b0;
  logic [31:0] last_rdata = '0;
  logic [31:0] last_w_addr = 32'd5;
  logic [31:0] last_w_data = 32'hDEADBEEF;

  int n_cmp = 0;
  int n_err = 0;
  int both_hi = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && bus.rsp_valid === 1'b1 && bus.req_ready === 1'b1) both_hi++;
  end

  task automatic wait_ready();
    int t = 0;
    while (bus.req_ready !== 1'b1 && t < 200) begin
      step();
      t++;
    end
    check("ready_wait", 32'(bus.req_ready), 32'd1);
  endtask

  task automatic drive_req(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    bus.req_valid = 1'b1;
    bus.req_wr    = wr;
    bus.req_addr  = addr;
    bus.req_wdata = data;
    step();
    bus.req_valid = 1'b0;
    bus.req_wr    = 1'($urandom);
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
  endtask

  task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input int delay);
    logic oob, elide, moved, saw_low;
    int   exp_lat, k;
    ram_delay = delay;
    wait_ready();
    if (bus.req_ready !== 1'b1) return;
    oob     = addr >= 32'd4096;
    elide   = !oob && wr && drv_wr && addr == drv_addr && data == drv_data;
    exp_lat = (oob || elide) ? 1 : 2 + delay;
    if (!oob && !elide) begin
      drv_addr = addr;
      drv_wr   = wr;
      drv_data = wr ? data : ~drv_data;
    end
    if (!oob) begin
      if (wr) begin
        ref_mem[addr[11:0]] = data;
        last_w_addr = addr;
        last_w_data = data;
      end else begin
        last_rdata = ref_mem[addr[11:0]];
      end
    end
    drive_req(wr, addr, data);
    moved = 1'b0;
    saw_low = 1'b0;
    k = 0;
    while (k < 300) begin
      if (bus.mem_addr !== drv_addr || bus.mem_data !== drv_data || bus.mem_wr !== drv_wr)
        moved = 1'b1;
      if (bus.mem_response === 1'b0) saw_low = 1'b1;
      if (bus.rsp_valid === 1'b1) break;
      step();
      k++;
    end
    check("latency", 32'(k), 32'(exp_lat));
    check("rsp_err", 32'(bus.rsp_err), 32'(oob));
    check("rsp_rdata", bus.rsp_rdata, last_rdata);
    check("mem_lines", 32'(moved), 32'd0);
    if (oob || elide) check("no_ram_access", 32'(saw_low), 32'd0);
    step();
    check("rsp_pulse", 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    int gap;
    logic seen;
    for (int i = 0; i < 4096; i++) ref_mem[i] = '0;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    repeat (3) step();
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("rst_mem_data", bus.mem_data, 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
    rst = 1'b0;

    // Directed: write, elided repeat, two identical reads, out-of-range.
    do_txn(1'b1, 32'd5, 32'hDEADBEEF, 0);
    do_txn(1'b1, 32'd5, 32'hDEADBEEF, 0);
    do_txn(1'b0, 32'd5, 32'h0, 0);
    do_txn(1'b0, 32'd5, 32'h0, 0);
    do_txn(1'b0, 32'd4096, 32'h0, 0);
    do_txn(1'b0, 32'hFFFF_FFFF, 32'h0, 2);
    do_txn(1'b1, 32'd0, 32'h1234_5678, 1);

    // Reset while the RAM holds a write in its busy phase.
    ram_delay = 0;
    wait_ready();
    hold_low = 1'b1;
    seen = 1'b0;
    drive_req(1'b1, 32'd6, 32'hCAFE_F00D);
    ref_mem[6] = 32'hCAFE_F00D;
    repeat (3) begin
      if (bus.rsp_valid === 1'b1) seen = 1'b1;
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    drv_addr = '0; drv_data = '0; drv_wr = 1'b0; last_rdata = '0;
    check("abort_mem_addr", bus.mem_addr, 32'd0);
    check("abort_mem_wr", 32'(bus.mem_wr), 32'd0);
    for (int i = 0; i < 8; i++) begin
      if (bus.rsp_valid === 1'b1) seen = 1'b1;
      if (bus.req_ready !== 1'b0) seen = 1'b1;
      step();
    end
    check("abort_quiet", 32'(seen), 32'd0);
    hold_low = 1'b0;
    do_txn(1'b0, 32'd0, 32'h0, 0);
    do_txn(1'b0, 32'd6, 32'h0, 1);

`ifdef RAM_REQ_TIMEOUT_EN
    // Stuck-high response: abort after 8 cycles, then resync.
    begin
      int k;
      ram_delay = 0;
      wait_ready();
      hold_high = 1'b1;
      drv_data = ~drv_data; drv_addr = 32'd5; drv_wr = 1'b0;
      drive_req(1'b0, 32'd5, 32'h0);
      k = 0;
      while (k < 100 && bus.rsp_valid !== 1'b1) begin
        step();
        k++;
      end
      check("to_latency", 32'(k), 32'd8);
      check("to_err", 32'(bus.rsp_err), 32'd1);
      repeat (4) step();
      hold_high = 1'b0;
      repeat (4) step();
    end
`endif

    // Randomized traffic, with frequent exact write repeats to hit elision.
    for (int n = 0; n < 150; n++) begin
      logic        wr;
      logic [31:0] addr, data;
      int          r;
      r = int'($urandom_range(0, 15));
      wr = 1'($urandom);
      data = $urandom;
      if (r == 0) addr = (($urandom & 1) != 0) ? 32'd4096 + $urandom_range(0, 99) : 32'hFFFF_FFF0;
      else if (r == 1) addr = 32'd4095;
      else addr = 32'($urandom_range(0, 15));
      if (r >= 12) begin
        wr = 1'b1;
        addr = last_w_addr;
        data = last_w_data;
      end
      gap = int'($urandom_range(0, 2));
      repeat (gap) step();
      do_txn(wr, addr, data, int'($urandom_range(0, 3)));
    end

    check("ready_rsp_excl", 32'(both_hi), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
